// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths and gray/binary pointer conversion
// used by both the read and write halves.
package fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  // Conversions work on a wide vector; callers zero-extend narrower pointers and
  // truncate the result, which is exact because the extra gray/binary bits are zero.
  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gvec_t;

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gvec_t gray2bin(input gvec_t g);
    gvec_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchroniser for a gray-coded pointer crossing clock domains.
module ptr_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q1_q, q2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: synchronised empty/level tracking and a
// first-word-fall-through output register with valid/ready handshake.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_gptr_async,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_gptr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   mem_level
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0]     wq2, wr_bin_s;
  logic [PW-1:0]     rd_bin_q, rd_bin_d;
  logic [PW-1:0]     rd_gptr_q, rd_gptr_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              mem_empty, fetch;
  logic [31:0]       rd_total;

  ptr_sync #(.W(PW)) u_wptr_sync (
    .clk (clk),
    .rst (rst),
    .d_i (wr_gptr_async),
    .q_o (wq2)
  );

  assign wr_bin_s = PW'(gray2bin(gvec_t'(wq2)));

  // Both sides of the compare are flops, so empty cannot glitch mid-cycle.
  assign mem_empty = (rd_gptr_q == wq2);
  assign fetch     = !mem_empty && (!rd_valid_q || rd_ready);

  always_comb begin
    rd_bin_d  = rd_bin_q + PW'(1);
    rd_gptr_d = PW'(bin2gray(gvec_t'(rd_bin_d)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bin_q   <= '0;
      rd_gptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (fetch) begin
      rd_data_q  <= mem_rdata;
      rd_valid_q <= 1'b1;
      rd_bin_q   <= rd_bin_d;
      rd_gptr_q  <= rd_gptr_d;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_q <= 1'b0;
    end
  end

  assign mem_level    = wr_bin_s - rd_bin_q;
  assign rd_total     = 32'(mem_level) + 32'(rd_valid_q);
  assign almost_empty = (rd_total <= 32'(AE_THRESH));

  assign rd_addr  = rd_bin_q[ADDR_W-1:0];
  assign rd_gptr  = rd_gptr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = !rd_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: the bench plays the write side and memory, a queue holds
// the words expected in order, and a negedge monitor checks every handshake.
module tb_fifo_rd_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int PW = AW + 1;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wr_gptr_async;
  logic [DW-1:0] mem_rdata;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_gptr;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, almost_empty;
  logic [PW-1:0] mem_level;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] wbin, prev_gptr, rb_m;
  int n_cmp = 0, n_bad = 0;
  int written = 0, popped = 0, fetch_cnt = 0;

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AE_THRESH(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_gptr_async (wr_gptr_async),
    .mem_rdata     (mem_rdata),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_gptr       (rd_gptr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .mem_level     (mem_level)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[rd_addr];

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: ordering of popped data, empty/valid relation, pointer sequence, level bound.
  always @(negedge clk) begin
    if (rst) begin
      chk("empty_inv", 32'(empty), 32'(!rd_valid));
      rb_m = g2b(rd_gptr);
      chk("rd_addr_ptr", 32'(rd_addr), 32'(rb_m[AW-1:0]));
      if (rd_gptr !== prev_gptr) begin
        fetch_cnt++;
        chk("gray_1bit", 32'($countones(rd_gptr ^ prev_gptr)), 32'd1);
        chk("gray_seq", 32'(rd_gptr), 32'(b2g(PW'(fetch_cnt))));
        chk("gray_msb", 32'(rd_gptr[PW-1] ^ prev_gptr[PW-1]), 32'((fetch_cnt % DEPTH) == 0));
        prev_gptr = rd_gptr;
      end
      chk("level_bound", 32'((int'(mem_level) + int'(rd_valid)) <= (written - popped)), 32'd1);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL data: got %0h, expected no word (queue empty)", rd_data);
        end else begin
          chk("data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        popped++;
      end
    end
  end

  task automatic tb_clear();
    exp_q.delete();
    written = 0;
    popped = 0;
    fetch_cnt = 0;
    prev_gptr = '0;
    wbin = '0;
    wr_gptr_async = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rd_ready = 1'b0;
    tb_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_gptr", 32'(rd_gptr), 32'd0);
    chk("rst_level", 32'(mem_level), 32'd0);
    rst = 1'b1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + PW'(1);
    written++;
    wr_gptr_async = b2g(wbin);
  endtask

  task automatic drain(input int budget);
    rd_ready = 1'b1;
    repeat (budget) @(posedge clk);
    #1;
    rd_ready = 1'b0;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vcnt, starts;
    logic pv;
    logic [PW-1:0] rb;
    bit done;
    rst = 1'b0;
    rd_ready = 1'b0;
    tb_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Single word: visible on exactly the third edge, then parked under backpressure.
    do_reset();
    push_word(8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("first_lat_valid", 32'(rd_valid), 32'(k == 3));
    end
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_addr", 32'(rd_addr), 32'd1);
    chk("single_gptr", 32'(rd_gptr), 32'b0001);
    chk("single_ae", 32'(almost_empty), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_hold_valid", 32'(rd_valid), 32'd1);
    chk("single_hold_gptr", 32'(rd_gptr), 32'b0001);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("single_popped", 32'(rd_valid), 32'd0);

    // Streaming a full memory at one word per clock.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(8'(8'h10 + i));
    rd_ready = 1'b1;
    vcnt = 0; starts = 0; pv = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (rd_valid) vcnt++;
      if (rd_valid && !pv) starts++;
      pv = rd_valid;
    end
    chk("stream_cycles", 32'(vcnt), 32'd8);
    chk("stream_contig", 32'(starts), 32'd1);
    chk("stream_valid_end", 32'(rd_valid), 32'd0);
    chk("stream_gptr_end", 32'(rd_gptr), 32'b1100);
    chk("stream_level_end", 32'(mem_level), 32'd0);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);
    rd_ready = 1'b0;

    // Backpressure: one fetch only, then a single-cycle pop advances by one.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(8'(8'h10 + i));
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid", 32'(rd_valid), 32'd1);
    chk("bp_data", 32'(rd_data), 32'h10);
    chk("bp_level", 32'(mem_level), 32'd7);
    chk("bp_ae", 32'(almost_empty), 32'd0);
    chk("bp_addr", 32'(rd_addr), 32'd1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("bp_step_data", 32'(rd_data), 32'h11);
    chk("bp_step_level", 32'(mem_level), 32'd6);
    drain(12);

    // Random push/pop across several pointer wraps.
    do_reset();
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk); #1;
      rd_ready = ($urandom_range(0, 3) != 0);
      if (written < 40 && $urandom_range(0, 1) == 1) begin
        rb = g2b(rd_gptr);
        if (int'(PW'(wbin - rb)) < DEPTH) push_word(8'($urandom));
      end
      if (written >= 40 && exp_q.size() == 0 && !rd_valid) done = 1'b1;
    end
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_popped", 32'(popped), 32'd40);
    rd_ready = 1'b0;

    // Asynchronous reset while a word is held.
    do_reset();
    for (int i = 0; i < 3; i++) push_word(8'(8'h60 + i));
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    chk("ar_pre_valid", 32'(rd_valid), 32'd1);
    rst = 1'b0;
    tb_clear();
    #1;
    chk("ar_valid", 32'(rd_valid), 32'd0);
    chk("ar_gptr", 32'(rd_gptr), 32'd0);
    chk("ar_level", 32'(mem_level), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
